// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and limits for the bit-serial subtractor.
//   state_e   - controller state encoding (IDLE, RUN, DONE), 2 bits
//   MAX_WIDTH - largest operand width the block is intended for
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/half_subtractor.sv
// half_subtractor: single-bit a - b without borrow-in.
//   a, b : input bits
//   d    : difference bit (a ^ b)
//   bo   : borrow out (~a & b)
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);

  assign d  = a ^ b;
  assign bo = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b,
// one bit per clock, LSB first, with a start/busy/done handshake.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous reset, active low
//   start      - request; accepted in IDLE or DONE
//   a, b       - minuend / subtrahend, captured on the accepting edge
//   busy       - high while bits are being processed
//   done       - one-cycle pulse when diff/borrow_out are updated
//   diff       - a - b mod 2^WIDTH, held until the next completion or reset
//   borrow_out - 1 when unsigned a < b
//   overflow   - signed overflow flag (only with SERIAL_SUB_SIGNED_EN)
//
// Build option: define SERIAL_SUB_SIGNED_EN to add the overflow port.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit consumed per edge, LSB first
// DONE  | results valid, done high; start accepted here too
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_SIGNED_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Result bits below the MSB; the MSB is the bit produced on the final edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_SIGNED_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             overflow_q, overflow_d;
`endif

  logic             d1, bo1, d_bit, bo2, bn;
  logic [WIDTH-1:0] res_wide;

  // Full-subtract cell: (a_bit - b_bit) - borrow.
  half_subtractor u_hs0 (.a(a_sr_q[0]), .b(b_sr_q[0]), .d(d1),    .bo(bo1));
  half_subtractor u_hs1 (.a(d1),        .b(borrow_q),  .d(d_bit), .bo(bo2));

  assign bn       = bo1 | bo2;
  assign res_wide = {d_bit, res_q};

  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    res_d        = res_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_SIGNED_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    overflow_d   = overflow_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
`ifdef SERIAL_SUB_SIGNED_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_d    = res_wide[WIDTH-1:1];
        borrow_d = bn;
        cnt_d    = cnt_q + CNT_W'(1);
        busy_d   = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d      = DONE;
          diff_d       = res_wide;
          borrow_out_d = bn;
          busy_d       = 1'b0;
          done_d       = 1'b1;
`ifdef SERIAL_SUB_SIGNED_EN
          overflow_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      res_q        <= res_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_SIGNED_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      overflow_q   <= overflow_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_SIGNED_EN
  assign overflow   = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8): table-driven operations plus
// hand-written sequences for mid-RUN start, back-to-back and mid-RUN reset.
// Overflow checks are compiled in when SERIAL_SUB_SIGNED_EN is defined.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] diff;
  logic       borrow_out;
`ifdef SERIAL_SUB_SIGNED_EN
  logic       overflow;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] prev_diff;
  logic       prev_bo;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drives one operation; operands are scrambled after acceptance, and an
  // ignored start with other operands is injected at RUN cycle 'inject' (0 = none).
  task automatic run_op(input string nm, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] exp_d, input logic exp_bo, input logic exp_ov,
                        input int inject);
    int lat;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      chk({nm, ".diff_hold"}, 64'(diff), 64'(prev_diff));
      chk({nm, ".bo_hold"}, 64'(borrow_out), 64'(prev_bo));
      if (lat == inject) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end else begin
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({nm, ".latency"}, 64'(lat - 1), 64'd8);
    chk({nm, ".busy_cycles"}, 64'(busy_cnt), 64'd8);
    chk({nm, ".busy_at_done"}, 64'(busy), 64'd0);
    chk({nm, ".diff"}, 64'(diff), 64'(exp_d));
    chk({nm, ".borrow"}, 64'(borrow_out), 64'(exp_bo));
`ifdef SERIAL_SUB_SIGNED_EN
    chk({nm, ".overflow"}, 64'(overflow), 64'(exp_ov));
`else
    if (exp_ov === 1'bx) $display("note: unknown overflow expectation in %s", nm);
`endif
    prev_diff = exp_d;
    prev_bo   = exp_bo;
    @(negedge clk);
    chk({nm, ".done_pulse"}, 64'(done), 64'd0);
    chk({nm, ".diff_after"}, 64'(diff), 64'(exp_d));
  endtask

  initial begin
    int n;
    int done_seen;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, d: 8'h1E, bo: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 8'h80, b: 8'h80, d: 8'h00, bo: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bo: 1'b1, ov: 1'b1};
    vecs[5] = '{a: 8'h01, b: 8'hFF, d: 8'h02, bo: 1'b1, ov: 1'b0};
    vecs[6] = '{a: 8'hC8, b: 8'h64, d: 8'h64, bo: 1'b0, ov: 1'b1};
    vecs[7] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0, ov: 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.diff", 64'(diff), 64'd0);
    chk("reset.borrow", 64'(borrow_out), 64'd0);
`ifdef SERIAL_SUB_SIGNED_EN
    chk("reset.overflow", 64'(overflow), 64'd0);
`endif
    rst_n = 1'b1;
    prev_diff = 8'h00;
    prev_bo   = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].ov, 0);

    // start with other operands during RUN must not disturb the result
    run_op("midrun_start", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 3);

    // back-to-back: start held through RUN and DONE
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    @(negedge clk);
    a = 8'h10; b = 8'h20;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.first_latency", 64'(n - 1), 64'd8);
    chk("b2b.first_diff", 64'(diff), 64'h1E);
    chk("b2b.first_borrow", 64'(borrow_out), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b.no_bubble", 64'(busy), 64'd1);
    chk("b2b.diff_hold", 64'(diff), 64'h1E);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.done_spacing", 64'(n), 64'd9);
    chk("b2b.second_diff", 64'(diff), 64'hF0);
    chk("b2b.second_borrow", 64'(borrow_out), 64'd1);
    prev_diff = 8'hF0;
    prev_bo   = 1'b1;
    @(negedge clk);

    // reset in the middle of RUN discards the operation
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.diff", 64'(diff), 64'd0);
    chk("midrst.borrow", 64'(borrow_out), 64'd0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("midrst.no_done", 64'(done_seen), 64'd0);
    prev_diff = 8'h00;
    prev_bo   = 1'b0;
    run_op("after_reset", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
